// File: rtl/risc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : risc_fetch_unit
// Brief    : RISC-V instruction fetch stage: PC, imem req/ack, {pc,instr} FIFO.
//            Optional macro RISC_FETCH_MISALIGN_CHK_EN adds a sticky
//            misaligned-target halt.
// Revision : 1.0 - initial release
// ============================================================================
module risc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr_32,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata_32,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_32,
    output logic [31:0] pc_32,
    input  logic        PCSRC,
    input  logic [31:0] target_32,
    output logic        misalign_err
);

    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_fetch_pc;
    logic [31:0]         r_drain_addr;
    logic [31:0]         r_pc_mem  [FIFO_DEPTH];
    logic [31:0]         r_ins_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  w_count_nxt;
    logic                w_ack;
    logic                w_push;
    logic                w_pop;
    logic                w_halt;
    logic [31:0]         w_target;

    assign w_target    = target_32 & ~32'h0000_0003;
    // Acks outside an active request (e.g. a response landing after reset) are ignored.
    assign w_ack       = imem_ack & imem_req;
    assign w_push      = w_ack & (r_state == REQ) & ~PCSRC;
    assign w_pop       = instr_valid & instr_ready & ~PCSRC;
    assign w_count_nxt = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

`ifdef RISC_FETCH_MISALIGN_CHK_EN
    logic r_misalign;
    logic w_set_mis;

    assign w_set_mis = PCSRC & (target_32[1:0] != 2'b00);
    assign w_halt    = r_misalign | w_set_mis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (w_set_mis) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign_err = r_misalign;
`else
    assign w_halt       = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        imem_req     = 1'b0;
        imem_addr_32 = 32'h0000_0000;
        case (r_state)
            IDLE: begin
                if (!w_halt && (PCSRC || (r_count != c_DEPTH))) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                imem_req     = 1'b1;
                imem_addr_32 = r_fetch_pc;
                if (PCSRC) begin
                    if (!w_ack) begin
                        w_state_nxt = DRAIN;
                    end else begin
                        w_state_nxt = w_halt ? IDLE : REQ;
                    end
                end else if (w_ack && (w_count_nxt == c_DEPTH)) begin
                    w_state_nxt = IDLE;
                end
            end
            DRAIN: begin
                // Old request must complete at its original address; its data is dropped.
                imem_req     = 1'b1;
                imem_addr_32 = r_drain_addr;
                if (w_ack) begin
                    w_state_nxt = w_halt ? IDLE : REQ;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_fetch_pc   <= RESET_PC;
            r_drain_addr <= 32'h0000_0000;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == REQ) && PCSRC && !w_ack) begin
                r_drain_addr <= r_fetch_pc;
            end
            if (PCSRC) begin
                r_fetch_pc <= w_target;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_push) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                    r_wr_ptr   <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                r_count <= w_count_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]  <= r_fetch_pc;
            r_ins_mem[r_wr_ptr] <= imem_rdata_32;
        end
    end

    assign instr_valid = (r_count != '0);
    assign instr_32    = instr_valid ? r_ins_mem[r_rd_ptr] : NOP_INSTR;
    assign pc_32       = instr_valid ? r_pc_mem[r_rd_ptr]  : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_risc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc_fetch_unit
// Brief    : Directed and randomized checks of risc_fetch_unit against an
//            instruction-stream reference model and a latency-configurable memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_risc_fetch_unit;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr_32;
    logic        imem_ack;
    logic [31:0] imem_rdata_32;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_32;
    logic [31:0] pc_32;
    logic        PCSRC = 1'b0;
    logic [31:0] target_32 = 32'h0;
    logic        misalign_err;

    int n_assert = 0;
    int n_fail   = 0;

    int wcnt      = 0;
    int cur_lat   = 0;
    int lat_fix   = 0;
    bit rand_mode = 1'b0;

    risc_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2),
        .NOP_INSTR  (c_NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr_32  (imem_addr_32),
        .imem_ack      (imem_ack),
        .imem_rdata_32 (imem_rdata_32),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_32      (instr_32),
        .pc_32         (pc_32),
        .PCSRC         (PCSRC),
        .target_32     (target_32),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory: ack after the request has been held for the chosen latency.
    assign imem_ack      = imem_req && (wcnt >= (rand_mode ? cur_lat : lat_fix));
    assign imem_rdata_32 = memfn(imem_addr_32);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= 0;
        end else if (imem_req && !imem_ack) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
            if (imem_ack) cur_lat <= int'($urandom_range(0, 2));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        PCSRC = 1'b0;
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic [31:0] rnd;
        bit          prev_pend;
        bit          post_redir;
        int          pops;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_addr",  imem_addr_32, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr_32, c_NOP);
        chk("rst_pc",    pc_32, 32'h0);
        chk("rst_mis",   32'(misalign_err), 32'd0);

        // ---------------- zero-wait streaming ----------------
        lat_fix = 0;
        instr_ready = 1'b1;
        rst = 1'b0;
        wait_req();
        for (int i = 0; i < 4; i++) begin
            chk("stream_addr", imem_addr_32, 32'(4 * i));
            if (i > 0) begin
                chk("stream_valid", 32'(instr_valid), 32'd1);
                chk("stream_pc",    pc_32, 32'(4 * (i - 1)));
                chk("stream_instr", instr_32, memfn(32'(4 * (i - 1))));
            end
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(instr_valid), 32'd0);
        chk("async_rst_req",   32'(imem_req), 32'd0);
        chk("async_rst_instr", instr_32, c_NOP);
        chk("async_rst_pc",    pc_32, 32'h0);

        // ---------------- latency 3, no consumption ----------------
        lat_fix = 3;
        do_reset();
        repeat (30) @(negedge clk);
        chk("fill_req",   32'(imem_req), 32'd0);
        chk("fill_valid", 32'(instr_valid), 32'd1);
        chk("fill_pc0",   pc_32, 32'h0);
        chk("fill_ins0",  instr_32, memfn(32'h0));
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("fill_pc1",   pc_32, 32'h4);
        chk("fill_ins1",  instr_32, memfn(32'h4));

        // ---------------- redirect while outstanding -> DRAIN ----------------
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 60 && !(imem_req && imem_addr_32 == 32'h10 && !imem_ack); i++)
            @(negedge clk);
        chk("drain_setup", imem_addr_32, 32'h10);
        PCSRC = 1'b1;
        target_32 = 32'h0000_0100;
        @(negedge clk);
        PCSRC = 1'b0;
        chk("drain_req",   32'(imem_req), 32'd1);
        chk("drain_addr",  imem_addr_32, 32'h10);
        chk("drain_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 10 && imem_addr_32 == 32'h10; i++) begin
            chk("drain_noinstr", 32'(instr_valid), 32'd0);
            @(negedge clk);
        end
        chk("drain_newaddr", imem_addr_32, 32'h100);
        for (int i = 0; i < 10 && !instr_valid; i++) @(negedge clk);
        chk("drain_first_pc", pc_32, 32'h100);

        // ---------------- redirect coincident with ack, FIFO filling ----------------
        lat_fix = 0;
        do_reset();
        wait_req();
        @(negedge clk);
        chk("coin_ack",   32'(imem_ack), 32'd1);
        chk("coin_valid", 32'(instr_valid), 32'd1);
        PCSRC = 1'b1;
        target_32 = 32'h0000_0200;
        @(negedge clk);
        PCSRC = 1'b0;
        chk("coin_flush", 32'(instr_valid), 32'd0);
        chk("coin_addr",  imem_addr_32, 32'h200);
        @(negedge clk);
        chk("coin_pc",    pc_32, 32'h200);

        // ---------------- PC wrap ----------------
        instr_ready = 1'b1;
        PCSRC = 1'b1;
        target_32 = 32'hFFFF_FFFC;
        @(negedge clk);
        PCSRC = 1'b0;
        chk("wrap_addr0", imem_addr_32, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_addr1", imem_addr_32, 32'h0);
        chk("wrap_pc",    pc_32, 32'hFFFF_FFFC);

        // ---------------- misaligned target ----------------
        PCSRC = 1'b1;
        target_32 = 32'h0000_0102;
        @(negedge clk);
        PCSRC = 1'b0;
`ifdef RISC_FETCH_MISALIGN_CHK_EN
        chk("mis_flag", 32'(misalign_err), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("mis_req",   32'(imem_req), 32'd0);
            chk("mis_valid", 32'(instr_valid), 32'd0);
            chk("mis_instr", instr_32, c_NOP);
            @(negedge clk);
        end
`else
        chk("mis_flag", 32'(misalign_err), 32'd0);
        chk("mis_addr", imem_addr_32, 32'h100);
        @(negedge clk);
        chk("mis_pc",   pc_32, 32'h100);
`endif

        // ---------------- randomized run vs instruction-stream model ----------------
        rand_mode = 1'b1;
        do_reset();
        exp_pc = 32'h0;
        prev_pend = 1'b0;
        prev_addr = 32'h0;
        post_redir = 1'b0;
        pops = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            if (post_redir) chk("rnd_redir_valid", 32'(instr_valid), 32'd0);
            if (instr_valid) begin
                chk("rnd_pc",    pc_32, exp_pc);
                chk("rnd_instr", instr_32, memfn(pc_32));
            end else begin
                chk("rnd_nop",   instr_32, c_NOP);
                chk("rnd_pc0",   pc_32, 32'h0);
            end
            if (prev_pend) begin
                chk("rnd_req_hold",  32'(imem_req), 32'd1);
                chk("rnd_addr_hold", imem_addr_32, prev_addr);
            end
            chk("rnd_addr_align", 32'(imem_addr_32[1:0]), 32'd0);

            instr_ready = ($urandom_range(0, 3) != 0);
            PCSRC = ($urandom_range(0, 15) == 0);
            rnd = $urandom;
            target_32 = rnd & ~32'h3;

            prev_pend = imem_req && !imem_ack;
            prev_addr = imem_addr_32;
            if (PCSRC) begin
                exp_pc = target_32;
                post_redir = 1'b1;
            end else begin
                post_redir = 1'b0;
                if (instr_valid && instr_ready) begin
                    exp_pc = exp_pc + 32'd4;
                    pops++;
                end
            end
        end
        PCSRC = 1'b0;
        n_assert++;
        assert (pops > 150) else begin
            n_fail++;
            $error("FAIL rnd_throughput: observed %0d pops expected more than 150", pops);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
